// File: rtl/bus_pkg.sv
// Shared types and address-map constants for the CPU bus interconnect.
// The slave-select code doubles as the read tag stored in the return-order FIFO.
package bus_pkg;

    localparam int NUM_SLAVES = 3;

    localparam logic [3:0] PROG_PREFIX = 4'h1;
    localparam logic [3:0] RAM_PREFIX  = 4'h2;
    localparam logic [3:0] IO_PREFIX   = 4'hF;

    typedef enum logic [1:0] {
        PROG = 2'd0,
        RAM  = 2'd1,
        IO   = 2'd2,
        NULL = 2'd3
    } slave_sel_t;

    function automatic slave_sel_t decode_prefix(input logic [3:0] prefix);
        case (prefix)
            PROG_PREFIX: return PROG;
            RAM_PREFIX:  return RAM;
            IO_PREFIX:   return IO;
            default:     return NULL;
        endcase
    endfunction

    // NULL has no physical slave, so it maps to an all-zero strobe vector.
    function automatic logic [NUM_SLAVES-1:0] sel_onehot(input slave_sel_t sel);
        case (sel)
            PROG:    return 3'b001;
            RAM:     return 3'b010;
            IO:      return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/read_tag_fifo.sv
// Synchronous FIFO holding the slave tag of each outstanding read.
// Full/empty come from the registered count, so a pop never frees a slot in the same cycle.
module read_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; entries are only read after a push, and resetting them would cost a reset net per bit.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cpu_bus_interconnect.sv
// Address decoder and in-order read-return router between the CPU and three slaves.
// Requests are forwarded combinationally; returns are re-ordered via a tag FIFO and registered once.
module cpu_bus_interconnect
    import bus_pkg::*;
#(
    parameter int MAX_PENDING = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    m_ready,
    input  logic [31:0]             m_addr,
    input  logic [31:0]             m_write_data,
    input  logic [3:0]              m_byte_enable,
    input  logic                    m_write_req,
    input  logic                    m_read_req,
    output logic [31:0]             m_read_data,
    output logic                    m_read_data_valid,
    output logic [31:0]             s_addr,
    output logic [31:0]             s_write_data,
    output logic [3:0]              s_byte_enable,
    output logic [NUM_SLAVES-1:0]   s_write_req,
    output logic [NUM_SLAVES-1:0]   s_read_req,
    input  logic [NUM_SLAVES-1:0]   s_ready,
    input  logic [32*NUM_SLAVES-1:0] s_read_data,
    input  logic [NUM_SLAVES-1:0]   s_read_data_valid,
    output logic                    bus_error
);

    slave_sel_t            req_sel;
    slave_sel_t            head_sel;
    logic [1:0]            head_tag;
    logic [NUM_SLAVES-1:0] req_onehot;
    logic [NUM_SLAVES-1:0] head_onehot;
    logic [NUM_SLAVES-1:0] head_mask;
    logic [NUM_SLAVES-1:0] stray_strobe;
    logic                  slave_accept;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  read_accept;
    logic                  fifo_pop;
    logic                  null_access;
    logic                  error_event;
    logic [31:0]           head_data;

    assign s_addr        = m_addr;
    assign s_write_data  = m_write_data;
    assign s_byte_enable = m_byte_enable;

    assign req_sel      = decode_prefix(m_addr[31:28]);
    assign req_onehot   = sel_onehot(req_sel);
    assign slave_accept = (req_sel == NULL) | (|(s_ready & req_onehot));

    // Reads win over a simultaneous write; a full tag FIFO holds the read off entirely.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        s_read_req  = '0;
        s_write_req = '0;
        m_ready     = 1'b0;
        if (m_read_req) begin
            if (!fifo_full) begin
                s_read_req = req_onehot;
                m_ready    = slave_accept;
            end
        end else if (m_write_req) begin
            s_write_req = req_onehot;
            m_ready     = slave_accept;
        end
    end

    assign read_accept = m_read_req & m_ready;

    read_tag_fifo #(
        .DEPTH (MAX_PENDING),
        .WIDTH ($bits(slave_sel_t))
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (read_accept),
        .push_data (req_sel),
        .pop       (fifo_pop),
        .head      (head_tag),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_sel    = slave_sel_t'(head_tag);
    assign head_onehot = sel_onehot(head_sel);
    assign head_mask   = fifo_empty ? {NUM_SLAVES{1'b0}} : head_onehot;

    // A NULL head retires on its own; a real slave's head waits for that slave's strobe.
    assign fifo_pop = ~fifo_empty &
                      ((head_sel == NULL) | (|(s_read_data_valid & head_onehot)));

    assign stray_strobe = s_read_data_valid & ~head_mask;

    always_comb begin
        head_data = '0;
        case (head_sel)
            PROG:    head_data = s_read_data[31:0];
            RAM:     head_data = s_read_data[63:32];
            IO:      head_data = s_read_data[95:64];
            default: head_data = '0;
        endcase
    end

    assign null_access = (req_sel == NULL) &
                         (read_accept | (m_write_req & ~m_read_req));

    assign error_event = (|stray_strobe) | null_access | (m_read_req & m_write_req);

    always_ff @(posedge clk) begin
        if (reset) begin
            m_read_data       <= '0;
            m_read_data_valid <= 1'b0;
            bus_error         <= 1'b0;
        end else begin
            m_read_data_valid <= fifo_pop;
            if (fifo_pop)    m_read_data <= head_data;
            if (error_event) bus_error   <= 1'b1;
        end
    end

endmodule

// File: doc/cpu_bus_interconnect.md
# cpu_bus_interconnect

Address decoder and read-return router between `cpu` (the bus master) and the system's memory-mapped slaves: program RAM, data RAM and I/O. It decodes each CPU request by address prefix and forwards it to exactly one slave. It tracks outstanding reads in an in-order tag FIFO and returns each slave's read data to the CPU in request order. Unmapped accesses complete harmlessly and set a sticky error flag.

## Interface
Parameters:
- `MAX_PENDING`, default 4: outstanding-read capacity; power of two, ≥2.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `m_ready`  out  1  request accepted this cycle.
- `m_addr`  in  32  CPU byte address, word-aligned for reads.
- `m_write_data`  in  32  store data.
- `m_byte_enable`  in  4  store byte lanes.
- `m_write_req`  in  1  write request, held until `m_ready`.
- `m_read_req`  in  1  read request, held until `m_ready`.
- `m_read_data`  out  32  returned read data.
- `m_read_data_valid`  out  1  `m_read_data` valid; one pulse per read.
- `s_addr`  out  32  `m_addr` passthrough, shared by all slaves.
- `s_write_data`  out  32  passthrough, shared.
- `s_byte_enable`  out  4  passthrough, shared.
- `s_write_req`  out  3  per-slave write request; one-hot or zero.
- `s_read_req`  out  3  per-slave read request; one-hot or zero.
- `s_ready`  in  3  per-slave accept.
- `s_read_data`  in  96  slave i data at bits [32i+31:32i].
- `s_read_data_valid`  in  3  per-slave return strobe; each slave returns its own reads in order, at least 1 cycle after acceptance.
- `bus_error`  out  1  sticky flag: unmapped access or out-of-order return.

## Operation
- Decode uses `m_addr[31:28]`:
  - 0x1 selects slave 0 (program RAM).
  - 0x2 selects slave 1 (data RAM).
  - 0xF selects slave 2 (I/O).
  - Any other value selects NULL (internal).
- Request forwarding is combinational. `s_*_req[sel] = m_*_req`, with all other bits 0. `m_ready = s_ready[sel]`. For NULL, `m_ready = 1`.
- Read back-pressure: if `m_read_req` is high and the tag FIFO is full, drive `m_ready = 0` and `s_read_req = 0`.
- An accepted read is the event `m_read_req & m_ready`. It pushes tag `sel` (2 bits; NULL = 3) into the tag FIFO.
- Return path, evaluated at the FIFO head:
  - Head = slave i and `s_read_data_valid[i]`: pop, and register `m_read_data <= s_read_data[i]`, `m_read_data_valid <= 1`.
  - Head = NULL: pop on the first cycle it is at the head, and register data 32'h0 with valid 1.
  - `s_read_data_valid[j]` asserted while the head is not j (including when the FIFO is empty): the data is discarded and `bus_error` is set.
- Writes are never tagged and produce no return. A NULL write is accepted and dropped, and sets `bus_error`. A NULL read also sets `bus_error`.
- Push and pop in the same cycle leave the count unchanged. Both FIFO pointers wrap modulo `MAX_PENDING`. The count is `log2(MAX_PENDING)+1` bits wide.
- `m_read_req` and `m_write_req` high together is illegal. When it happens, the read takes priority and `bus_error` is set.

## Timing
- Reset values: `m_read_data` = 0, `m_read_data_valid` = 0, `bus_error` = 0, FIFO empty. Request outputs are combinational and are therefore 0 whenever the master requests nothing.
- Reset applied mid-operation: the FIFO is flushed immediately. Slave returns that arrive after reset hits an empty FIFO and set `bus_error`. The system resets the slaves together with this block.
- Read latency added: exactly 1 cycle. A slave strobe at cycle t gives `m_read_data_valid` at t+1.
- NULL read accepted at cycle t: the entry reaches the head at t+1 when the FIFO was empty, and `m_read_data_valid` follows at t+2.
- Throughput: 1 accept per cycle and 1 return per cycle.
- The FIFO is full at `MAX_PENDING` entries. It stays full in a cycle where it pops, so back-pressure uses the registered count (no pop bypass).

## Structure
- Package `bus_pkg` holds:
  - `slave_sel_t`: PROG = 0, RAM = 1, IO = 2, NULL = 3.
  - Address prefix constants PROG_PREFIX = 4'h1, RAM_PREFIX = 4'h2, IO_PREFIX = 4'hF.
  - NUM_SLAVES = 3.
- Sub-module `read_tag_fifo`: a synchronous FIFO parameterised on depth and width, with push, pop, full and empty.

## Test plan
- Read of 0x1000_0000, with slave 0 returning 0xCAFE_F00D after 3 cycles → `m_read_data_valid` pulses 1 cycle after the strobe with 0xCAFE_F00D; `s_read_req` = 3'b001.
- Back-to-back reads to slave 1 then slave 0, with slave 0 answering first → slave 0's data is dropped and `bus_error` = 1. A compliant ordering of the same reads returns both in issue order.
- Four reads accepted with no returns (`MAX_PENDING` = 4) → a fifth `m_read_req` sees `m_ready` = 0 until one return pops, then is accepted.
- Store to 0xF000_0004 with byte_enable 4'b0010 and I/O `s_ready` held low 2 cycles → `s_write_req` = 3'b100 held; `m_ready` rises with `s_ready[2]`; no read return occurs.
- Read of 0x5000_0000 → `m_ready` = 1 immediately; `m_read_data` = 0 with valid 2 cycles later; `bus_error` = 1.
- Reset asserted with 2 reads pending → the FIFO empties; `m_read_data_valid` and `bus_error` read 0 on the cycle after reset.
